pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter Psize, default 6, PC/branch-address width, matching the program counter it drives.
REQ-002 Parameter Opsize, default 4, opcode field width.
REQ-003 clk  input  1  system clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 opcode  input  Opsize  opcode field of the instruction currently addressed by the PC.
REQ-006 alu_z  input  1  ALU zero result for the current instruction.
REQ-007 in_valid  input  1  external data word present on the input port.
REQ-008 in_ack  output  1  input word consumed this cycle.
REQ-009 PCincr, PCabsbranch, PCrelbranch  output  1 each  program-counter control strobes.
REQ-010 w  output  1  register-file write enable.
REQ-011 alu_func  output  3  ALU operation select.
REQ-012 imm_sel  output  1  ALU operand B from immediate (1) or register (0).
REQ-013 in_sel  output  1  register-file write data from input port.
REQ-014 halted  output  1  sequencer stopped.

Function
REQ-015 Opcodes SHALL be: 0 NOP, 1 ADD, 2 ADDI, 3 SUB, 4 SUBI, 5 MULI, 6 BEQ (relative, if Z), 7 BNE (relative, if !Z), 8 JMP (absolute), 9 IN, 15 HALT; any other value decodes as NOP.
REQ-016 States SHALL be RUN, WAIT_IN, HALT; all control outputs are combinational from state, opcode, Z register, armed flag and in_valid (zero-latency decode).
REQ-017 In RUN, exactly one of PCincr/PCabsbranch/PCrelbranch SHALL be asserted per cycle, except IN-stall and HALT, where all three are 0.
REQ-018 ALU ops (1-5): w=1, PCincr=1, imm_sel=1 for ADDI/SUBI/MULI, alu_func per package encoding; Z register loads alu_z at the clock edge.
REQ-019 Non-ALU opcodes SHALL leave the Z register unchanged; branches test the registered Z, never the same-cycle alu_z.
REQ-020 BEQ/BNE taken: PCrelbranch=1; not taken: PCincr=1; JMP: PCabsbranch=1; NOP: PCincr=1; w=0 for all four.
REQ-021 IN in RUN with in_valid=1 and armed=1: w=1, in_sel=1, in_ack=1, PCincr=1, armed cleared, stay RUN.
REQ-022 IN in RUN otherwise: all PC strobes 0, w=0, next state WAIT_IN.
REQ-023 WAIT_IN: on in_valid=1 and armed=1, same outputs as REQ-021 and return to RUN; else hold with all strobes 0.
REQ-024 armed SHALL set when in_valid is sampled 0, so one held in_valid pulse is consumed at most once.
REQ-025 in_valid while not executing IN SHALL be ignored (no ack, no state change except REQ-024).
REQ-026 HALT: next state HALT, all strobes/w/in_ack 0; halted registered 1 from the cycle after decode until reset.

Reset
REQ-027 reset low SHALL asynchronously force state RUN, Z=0, armed=1, halted=0; reset mid-WAIT_IN or in HALT returns to RUN.
REQ-028 While reset is low, all outputs SHALL be 0.

Configuration
REQ-029 Macro PCSEQ_STEP_EN SHALL add input step (1 bit): instruction execution (any strobe, w, Z update, in_ack, state change) occurs only in cycles with step=1; step=0 forces all strobes/w/in_ack to 0 and holds state.
REQ-030 Without PCSEQ_STEP_EN, the step port is absent and execution proceeds every cycle.

Structure
REQ-031 Package pc_seq_pkg SHALL hold the opcode enum, alu_func encoding constants and the state enum.
REQ-032 Sub-module pc_seq_decode (pure combinational opcode -> control-field decode) is natural; the FSM, Z register and armed flag stay in pc_sequencer.

Verification
REQ-033 Reset, opcode=1 (ADD), alu_z=1 -> PCincr=1, w=1; next cycle opcode=6 (BEQ) -> PCrelbranch=1, PCincr=0.
REQ-034 SUB with alu_z=0, then NOP, then BNE -> Z stays 0 through NOP; BNE gives PCrelbranch=1.
REQ-035 IN with in_valid=0 for 3 cycles, then 1 -> no strobes for 3 cycles, then one cycle w=in_sel=in_ack=PCincr=1.
REQ-036 Two consecutive IN with in_valid held 1 -> first acked; second stalls in WAIT_IN until in_valid drops and rises again.
REQ-037 opcode=15 -> halted=1 next cycle, strobes 0 for 10 cycles; reset low mid-HALT -> halted=0, RUN.
REQ-038 With PCSEQ_STEP_EN, opcode=8, step=0 for 4 cycles then 1 -> PCabsbranch asserted only in the step cycle.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg -- shared definitions for the program-counter sequencer.
//   opcode_e : instruction opcode values (4-bit encoding)
//   ALU_*    : alu_func encodings driven to the ALU
//   state_e  : sequencer FSM states
package pc_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADDI = 4'd2,
    OP_SUB  = 4'd3,
    OP_SUBI = 4'd4,
    OP_MULI = 4'd5,
    OP_BEQ  = 4'd6,
    OP_BNE  = 4'd7,
    OP_JMP  = 4'd8,
    OP_IN   = 4'd9,
    OP_HALT = 4'd15
  } opcode_e;

  // ALU operation select; ALU_NONE is driven whenever no ALU op executes.
  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_MUL  = 3'd3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_IN = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

endpackage

// File: rtl/pc_seq_decode.sv
// pc_seq_decode -- pure combinational opcode decode.
// Ports:
//   opcode   in  [Opsize-1:0] instruction opcode field
//   is_alu   out  opcode is ADD/ADDI/SUB/SUBI/MULI
//   is_beq, is_bne, is_jmp, is_in, is_halt  out  instruction class flags
//   alu_func out [2:0] ALU operation for ALU opcodes, ALU_NONE otherwise
//   imm_sel  out  immediate operand B for ADDI/SUBI/MULI
// Unlisted opcodes raise no flag, which the sequencer treats as NOP.
module pc_seq_decode
  import pc_seq_pkg::*;
#(
  parameter int Opsize = 4
) (
  input  logic [Opsize-1:0] opcode,
  output logic              is_alu,
  output logic              is_beq,
  output logic              is_bne,
  output logic              is_jmp,
  output logic              is_in,
  output logic              is_halt,
  output logic [2:0]        alu_func,
  output logic              imm_sel
);

  always_comb begin
    is_alu   = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_jmp   = 1'b0;
    is_in    = 1'b0;
    is_halt  = 1'b0;
    alu_func = ALU_NONE;
    imm_sel  = 1'b0;
    case (opcode)
      Opsize'(OP_ADD):  begin is_alu = 1'b1; alu_func = ALU_ADD; end
      Opsize'(OP_ADDI): begin is_alu = 1'b1; alu_func = ALU_ADD; imm_sel = 1'b1; end
      Opsize'(OP_SUB):  begin is_alu = 1'b1; alu_func = ALU_SUB; end
      Opsize'(OP_SUBI): begin is_alu = 1'b1; alu_func = ALU_SUB; imm_sel = 1'b1; end
      Opsize'(OP_MULI): begin is_alu = 1'b1; alu_func = ALU_MUL; imm_sel = 1'b1; end
      Opsize'(OP_BEQ):  is_beq  = 1'b1;
      Opsize'(OP_BNE):  is_bne  = 1'b1;
      Opsize'(OP_JMP):  is_jmp  = 1'b1;
      Opsize'(OP_IN):   is_in   = 1'b1;
      Opsize'(OP_HALT): is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- control sequencer for a small accumulator-style CPU.
// Decodes the opcode addressed by the PC and drives PC, register-file and
// ALU controls combinationally; holds the Z flag, the input "armed" flag and
// the RUN / WAIT_IN / HALT state.
// Ports:
//   clk          in   system clock (posedge)
//   reset        in   asynchronous active-low reset
//   step         in   (only with PCSEQ_STEP_EN) execute an instruction this cycle
//   opcode       in   [Opsize-1:0] current instruction opcode
//   alu_z        in   ALU zero result of the current instruction
//   in_valid     in   input port holds a word
//   in_ack       out  input word consumed this cycle
//   PCincr, PCabsbranch, PCrelbranch  out  PC control strobes
//   w            out  register-file write enable
//   alu_func     out  [2:0] ALU operation select
//   imm_sel      out  ALU operand B from immediate
//   in_sel       out  register-file write data from input port
//   halted       out  sequencer stopped (registered)
// Configuration macro: PCSEQ_STEP_EN adds the step input (single-step mode).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int Psize  = 6,
  parameter int Opsize = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef PCSEQ_STEP_EN
  input  logic              step,
`endif
  input  logic [Opsize-1:0] opcode,
  input  logic              alu_z,
  input  logic              in_valid,
  output logic              in_ack,
  output logic              PCincr,
  output logic              PCabsbranch,
  output logic              PCrelbranch,
  output logic              w,
  output logic [2:0]        alu_func,
  output logic              imm_sel,
  output logic              in_sel,
  output logic              halted
);

  // Psize only keeps this block's parameters in line with the PC it drives;
  // no control decision depends on it.
  if (Psize < 1) begin : g_psize_check
  end

  state_e state_reg, state_next;
  logic   z_reg, z_next;
  logic   armed_reg, armed_next;
  logic   halted_reg, halted_next;
  logic   take_in;
  logic   exec;

`ifdef PCSEQ_STEP_EN
  assign exec = step;
`else
  assign exec = 1'b1;
`endif

  logic       d_is_alu, d_is_beq, d_is_bne, d_is_jmp, d_is_in, d_is_halt;
  logic [2:0] d_alu_func;
  logic       d_imm_sel;

  pc_seq_decode #(.Opsize(Opsize)) u_decode (
    .opcode   (opcode),
    .is_alu   (d_is_alu),
    .is_beq   (d_is_beq),
    .is_bne   (d_is_bne),
    .is_jmp   (d_is_jmp),
    .is_in    (d_is_in),
    .is_halt  (d_is_halt),
    .alu_func (d_alu_func),
    .imm_sel  (d_imm_sel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_RUN;
      z_reg      <= 1'b0;
      armed_reg  <= 1'b1;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      z_reg      <= z_next;
      armed_reg  <= armed_next;
      halted_reg <= halted_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    z_next      = z_reg;
    armed_next  = armed_reg;
    halted_next = halted_reg;
    take_in     = 1'b0;
    in_ack      = 1'b0;
    PCincr      = 1'b0;
    PCabsbranch = 1'b0;
    PCrelbranch = 1'b0;
    w           = 1'b0;
    alu_func    = ALU_NONE;
    imm_sel     = 1'b0;
    in_sel      = 1'b0;

    // Gating on reset keeps every output quiet while reset is held, even
    // though the state register already sits in RUN.
    if (reset && exec) begin
      case (state_reg)
        ST_RUN: begin
          if (d_is_alu) begin
            w        = 1'b1;
            PCincr   = 1'b1;
            alu_func = d_alu_func;
            imm_sel  = d_imm_sel;
            z_next   = alu_z;
          end else if (d_is_beq) begin
            // Branches use the Z left by the previous ALU op, not alu_z.
            if (z_reg) PCrelbranch = 1'b1;
            else       PCincr      = 1'b1;
          end else if (d_is_bne) begin
            if (!z_reg) PCrelbranch = 1'b1;
            else        PCincr      = 1'b1;
          end else if (d_is_jmp) begin
            PCabsbranch = 1'b1;
          end else if (d_is_in) begin
            if (in_valid && armed_reg) take_in    = 1'b1;
            else                       state_next = ST_WAIT_IN;
          end else if (d_is_halt) begin
            state_next  = ST_HALT;
            halted_next = 1'b1;
          end else begin
            PCincr = 1'b1;
          end
        end
        ST_WAIT_IN: begin
          if (in_valid && armed_reg) begin
            take_in    = 1'b1;
            state_next = ST_RUN;
          end
        end
        default: ;
      endcase
    end

    if (take_in) begin
      w      = 1'b1;
      in_sel = 1'b1;
      in_ack = 1'b1;
      PCincr = 1'b1;
    end

    // A held in_valid level is consumed once; it must be seen low before the
    // next word can be taken.
    if (take_in)       armed_next = 1'b0;
    else if (!in_valid) armed_next = 1'b1;
  end

  assign halted = halted_reg;

endmodule
